// File: rtl/bus_master.sv
// bus_master: host-side initiator at the head of the 16-bit core bus chain.
// Issues one bus strobe per request and collects the echo at the chain tail.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             host request: valid/ready, addr, wdata, rw (1=write)
//   resp_*            host response: valid/ready, data, err
//   addr_o..valid_o   bus drive toward chain head (nonzero only in ISSUE)
//   addr_i..valid_i   bus return from chain tail
//   busy_o            a transaction is in flight
module bus_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_data_i,
  input  logic        req_rw_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [15:0] resp_data_o,
  output logic        resp_err_o,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_live;
  logic [15:0]   r_addr;
  logic [15:0]   r_data;
  logic          r_rw;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_cap;
  logic          w_tout;
  logic          w_last;
  logic          w_mis;

  assign w_last = (r_cnt == LAST);
  assign w_mis  = (addr_i != r_addr) | (rw_i != r_rw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_live holds req_ready_o low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_addr <= req_addr_i;
        r_data <= req_data_i;
        r_rw   <= req_rw_i;
      end
      if (r_state == S_WAIT && !valid_i && !w_last) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_cap) begin
        r_rdata <= data_i;
        r_err   <= w_mis;
      end else if (w_tout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_cap        = 1'b0;
    w_tout       = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    resp_err_o   = 1'b0;
    addr_o       = '0;
    data_o       = '0;
    rw_o         = 1'b0;
    valid_o      = 1'b0;
    busy_o       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = r_live;
        if (req_valid_i && r_live) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        valid_o = 1'b1;
        addr_o  = r_addr;
        data_o  = r_data;
        rw_o    = r_rw;
        if (valid_i) begin
          w_cap  = 1'b1;
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // An echo on the timeout edge still counts as a real response.
        if (valid_i) begin
          w_cap  = 1'b1;
          w_next = S_RESP;
        end else if (w_last) begin
          w_tout = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_data_o  = r_rdata;
        resp_err_o   = r_err;
        if (resp_ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: randomized self-checking bench for bus_master.
// Expected responses come from a latency/echo model of each transaction.
module tb_bus_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_addr_i = '0;
  logic [15:0] req_data_i = '0;
  logic        req_rw_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [15:0] resp_data_o;
  logic        resp_err_o;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;
  logic [15:0] addr_i = '0;
  logic [15:0] data_i = '0;
  logic        rw_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_rw_i(req_rw_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .rw_o(rw_o),
    .valid_o(valid_o),
    .addr_i(addr_i),
    .data_i(data_i),
    .rw_i(rw_i),
    .valid_i(valid_i),
    .busy_o(busy_o)
  );

  // Reference: the echo counts if it arrives within TMO+1 edges of the
  // accept edge; otherwise the host sees a timeout at edge TMO+1.
  function automatic void model(
    input int lat, input logic [15:0] a, input logic r,
    input logic [15:0] ea, input logic [15:0] ed, input logic er,
    output int xl, output logic [15:0] xd, output logic xe);
    if (lat <= TMO + 1) begin
      xl = lat;
      xd = ed;
      xe = (ea != a) || (er != r);
    end else begin
      xl = TMO + 1;
      xd = 16'h0000;
      xe = 1'b1;
    end
  endfunction

  // Drives one request and a chain responder, observes the bus and the
  // response. o_lat counts cycles from the valid_o cycle to resp_valid_o.
  task automatic run_txn(
    input logic [15:0] a, input logic [15:0] d, input logic r,
    input int lat,
    input logic [15:0] ea, input logic [15:0] ed, input logic er,
    input int hold,
    input bit keep, input logic [15:0] ka, input logic [15:0] kd,
    input logic kr,
    output int o_strobes, output logic [15:0] o_addr,
    output logic [15:0] o_data, output logic o_rw,
    output int o_lat, output logic [15:0] o_rdata,
    output logic o_err, output bit o_ok);
    int k;
    int w;
    o_strobes = 0;
    o_addr = '0;
    o_data = '0;
    o_rw = 1'b0;
    o_lat = -1;
    o_rdata = '0;
    o_err = 1'b0;
    o_ok = 1'b1;
    req_addr_i = a;
    req_data_i = d;
    req_rw_i = r;
    req_valid_i = 1'b1;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (req_ready_o !== 1'b1) begin
      req_valid_i = 1'b0;
      o_ok = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep) begin
      req_addr_i = ka;
      req_data_i = kd;
      req_rw_i = kr;
    end else begin
      req_valid_i = 1'b0;
    end
    k = 1;
    while (k < TMO + 40) begin
      if (valid_o === 1'b1) begin
        o_strobes++;
        o_addr = addr_o;
        o_data = data_o;
        o_rw = rw_o;
      end else if (addr_o !== 16'h0 || data_o !== 16'h0 || rw_o !== 1'b0) begin
        o_ok = 1'b0;
      end
      if (req_ready_o !== 1'b0) o_ok = 1'b0;
      if (resp_valid_o === 1'b1) begin
        o_lat = k - 1;
        o_rdata = resp_data_o;
        o_err = resp_err_o;
        break;
      end
      valid_i = (k == lat);
      addr_i = ea;
      data_i = ed;
      rw_i = er;
      @(negedge clk);
      k++;
    end
    valid_i = 1'b0;
    if (o_lat < 0) begin
      o_ok = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      resp_ready_i = 1'b0;
      valid_i = 1'($urandom);
      addr_i = 16'($urandom);
      data_i = 16'($urandom);
      rw_i = 1'($urandom);
      @(negedge clk);
      if (resp_valid_o !== 1'b1 || resp_data_o !== o_rdata ||
          resp_err_o !== o_err || req_ready_o !== 1'b0 ||
          valid_o !== 1'b0)
        o_ok = 1'b0;
    end
    valid_i = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) o_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", req_ready_o);
    end
    checks++;
    if ({valid_o, addr_o, data_o, rw_o, resp_valid_o, resp_data_o,
         resp_err_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid_o=%b addr_o=%h data_o=%h rw_o=%b rv=%b rd=%h re=%b busy=%b want all 0",
               valid_o, addr_o, data_o, rw_o, resp_valid_o, resp_data_o,
               resp_err_o, busy_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b want 1/0",
               req_ready_o, busy_o);
    end
  endtask

  task automatic test_write();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    run_txn(16'h0003, 16'h1111, 1'b1, 2, 16'h0003, 16'h1111, 1'b1, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (st !== 1 || ba !== 16'h0003 || bd !== 16'h1111 || br !== 1'b1) begin
      errors++;
      $display("FAIL write_bus: strobes=%0d addr=%h data=%h rw=%b want 1/0003/1111/1",
               st, ba, bd, br);
    end
    checks++;
    if (lt !== 2 || rd !== 16'h1111 || re !== 1'b0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL write_resp: lat=%0d data=%h err=%b ok=%b want 2/1111/0/1",
               lt, rd, re, ok);
    end
  endtask

  task automatic test_read();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    run_txn(16'h0001, 16'h0000, 1'b0, 3, 16'h0001, 16'h2345, 1'b0, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (st !== 1 || ba !== 16'h0001 || br !== 1'b0) begin
      errors++;
      $display("FAIL read_bus: strobes=%0d addr=%h rw=%b want 1/0001/0",
               st, ba, br);
    end
    checks++;
    if (lt !== 3 || rd !== 16'h2345 || re !== 1'b0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL read_resp: lat=%0d data=%h err=%b ok=%b want 3/2345/0/1",
               lt, rd, re, ok);
    end
  endtask

  task automatic test_timeout();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    run_txn(16'h0009, 16'h0000, 1'b0, 1000, 16'h0009, 16'h5555, 1'b0, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (lt !== TMO + 1 || rd !== 16'h0000 || re !== 1'b1 || st !== 1) begin
      errors++;
      $display("FAIL timeout_resp: lat=%0d data=%h err=%b strobes=%0d want %0d/0000/1/1",
               lt, rd, re, st, TMO + 1);
    end
    repeat (4) @(negedge clk);
    valid_i = 1'b1;
    addr_i = 16'h0009;
    data_i = 16'h5555;
    rw_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL late_drop: cycle %0d rv=%b ready=%b busy=%b want 0/1/0",
                 i, resp_valid_o, req_ready_o, busy_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    run_txn(16'h0010, 16'hAAAA, 1'b1, 1, 16'h0010, 16'hAAAA, 1'b1, 5,
            1'b1, 16'h0020, 16'h7777, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (ok !== 1'b1 || st !== 1) begin
      errors++;
      $display("FAIL bp_hold: ok=%b strobes=%0d want 1/1", ok, st);
    end
    checks++;
    if (lt !== 1 || rd !== 16'hAAAA || re !== 1'b0) begin
      errors++;
      $display("FAIL bp_resp: lat=%0d data=%h err=%b want 1/aaaa/0",
               lt, rd, re);
    end
    run_txn(16'h0020, 16'h7777, 1'b0, 1, 16'h0020, 16'h0C0C, 1'b0, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (st !== 1 || ba !== 16'h0020 || rd !== 16'h0C0C || re !== 1'b0 ||
        ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: strobes=%0d addr=%h data=%h err=%b ok=%b want 1/0020/0c0c/0/1",
               st, ba, rd, re, ok);
    end
  endtask

  task automatic test_mismatch();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    run_txn(16'h0005, 16'h0000, 1'b0, 2, 16'h0006, 16'hBEEF, 1'b0, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (rd !== 16'hBEEF || re !== 1'b1 || lt !== 2) begin
      errors++;
      $display("FAIL mismatch_resp: data=%h err=%b lat=%0d want beef/1/2",
               rd, re, lt);
    end
  endtask

  task automatic test_reset_in_wait();
    int st, lt;
    logic [15:0] ba, bd, rd;
    logic br, re;
    bit ok;
    req_addr_i = 16'h0007;
    req_data_i = 16'h3333;
    req_rw_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre: busy=%b rv=%b want 1/0", busy_o, resp_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, valid_o, addr_o, data_o, rw_o, resp_valid_o,
         resp_data_o, resp_err_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: ready=%b valid_o=%b addr_o=%h busy=%b want all 0",
               req_ready_o, valid_o, addr_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid_i = 1'b1;
    addr_i = 16'h0007;
    data_i = 16'h3333;
    rw_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: cycle %0d rv=%b busy=%b valid_o=%b want 0/0/0",
                 i, resp_valid_o, busy_o, valid_o);
      end
      @(negedge clk);
    end
    run_txn(16'h0004, 16'h4444, 1'b1, 2, 16'h0004, 16'h4444, 1'b1, 0,
            1'b0, 16'h0, 16'h0, 1'b0, st, ba, bd, br, lt, rd, re, ok);
    checks++;
    if (st !== 1 || ba !== 16'h0004 || bd !== 16'h4444 || lt !== 2 ||
        rd !== 16'h4444 || re !== 1'b0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_write: strobes=%0d addr=%h lat=%0d data=%h err=%b ok=%b",
               st, ba, lt, rd, re, ok);
    end
  endtask

  task automatic test_random();
    int st, lt, lat, hold, xl;
    logic [15:0] a, d, ea, ed, ba, bd, rd, xd;
    logic r, er, br, re, xe;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom);
      d = 16'($urandom);
      r = 1'($urandom);
      lat = $urandom_range(1, TMO + 3);
      hold = $urandom_range(0, 3);
      ea = a;
      er = r;
      ed = r ? d : 16'($urandom);
      if ($urandom_range(0, 3) == 0) ea = a ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) er = ~r;
      model(lat, a, r, ea, ed, er, xl, xd, xe);
      run_txn(a, d, r, lat, ea, ed, er, hold, 1'b0, 16'h0, 16'h0, 1'b0,
              st, ba, bd, br, lt, rd, re, ok);
      checks++;
      if (st !== 1 || ba !== a || bd !== d || br !== r) begin
        errors++;
        $display("FAIL rnd%0d_bus: strobes=%0d addr=%h data=%h rw=%b want 1/%h/%h/%b",
                 n, st, ba, bd, br, a, d, r);
      end
      checks++;
      if (lt !== xl) begin
        errors++;
        $display("FAIL rnd%0d_lat: got %0d want %0d (L=%0d)", n, lt, xl, lat);
      end
      checks++;
      if (rd !== xd || re !== xe) begin
        errors++;
        $display("FAIL rnd%0d_resp: data=%h err=%b want %h/%b", n, rd, re, xd, xe);
      end
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_proto: ok=%b want 1 (hold=%0d)", n, ok, hold);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_mismatch();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
